alu_share_ctrl: RTL and testbench

//  Two-requester round-robin controller that shares a single 6-bit ALU (fxn-coded, combinational) between two clients.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_share_ctrl_rr_arb2.sv | 20 ++
 rtl/alu_share_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: fxn codes, FSM states, helpers.
package alu_pkg;

  localparam int unsigned ALU_W = 6;
  localparam int unsigned FXN_W = 3;

  localparam logic [FXN_W-1:0] FXN_PASS_A = 3'b000;
  localparam logic [FXN_W-1:0] FXN_PASS_B = 3'b001;
  localparam logic [FXN_W-1:0] FXN_NEG_A  = 3'b010;
  localparam logic [FXN_W-1:0] FXN_NEG_B  = 3'b011;
  localparam logic [FXN_W-1:0] FXN_LT     = 3'b100;
  localparam logic [FXN_W-1:0] FXN_XNOR   = 3'b101;
  localparam logic [FXN_W-1:0] FXN_ADD    = 3'b110;
  localparam logic [FXN_W-1:0] FXN_SUB    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Client index to one-hot 2-bit vector.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant favouring the client that did not win last.
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant_c
);

  always_comb begin
    o_grant_c = 2'b00;
    case (i_valid)
      2'b01:   o_grant_c = 2'b01;
      2'b10:   o_grant_c = 2'b10;
      2'b11:   o_grant_c = onehot2(~i_last_grant);
      default: o_grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two clients: arbitrate, hold operands for
// ALU_LAT cycles, capture X and return it to the granted client.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W       = ALU_W,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  input  logic [5:0]       req_fxn,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [W-1:0]     resp_data,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [FXN_W-1:0] alu_fxn,
  input  logic [W-1:0]     alu_x,
  output logic             busy
);

  localparam int unsigned      CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_grant, w_grant_nxt;
  logic               r_last_grant, w_last_grant_nxt;
  logic [W-1:0]       r_alu_a, w_alu_a_nxt;
  logic [W-1:0]       r_alu_b, w_alu_b_nxt;
  logic [FXN_W-1:0]   r_alu_fxn, w_alu_fxn_nxt;
  logic [W-1:0]       r_resp_data, w_resp_data_nxt;
  logic [1:0]         r_resp_valid, w_resp_valid_nxt;
  logic               r_busy, w_busy_nxt;

  logic [1:0]         w_arb_grant;
  logic               w_pick;
  logic [W-1:0]       w_sel_a, w_sel_b;
  logic [FXN_W-1:0]   w_sel_fxn;

  rr_arb2 u_arb (
    .i_valid      (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant_c    (w_arb_grant)
  );

  // Operand mux for whichever client the arbiter picks this cycle.
  assign w_pick    = w_arb_grant[1];
  assign w_sel_a   = w_pick ? req_a[2*W-1:W]   : req_a[W-1:0];
  assign w_sel_b   = w_pick ? req_b[2*W-1:W]   : req_b[W-1:0];
  assign w_sel_fxn = w_pick ? req_fxn[5:3]     : req_fxn[2:0];

  // Accept is offered only from IDLE and is forced low while reset is held.
  assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_arb_grant : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_fxn_nxt    = r_alu_fxn;
    w_resp_data_nxt  = r_resp_data;
    w_resp_valid_nxt = r_resp_valid;
    w_busy_nxt       = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_grant != 2'b00) begin
          w_alu_a_nxt   = w_sel_a;
          w_alu_b_nxt   = w_sel_b;
          w_alu_fxn_nxt = w_sel_fxn;
          w_grant_nxt   = w_pick;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_resp_data_nxt  = alu_x;
          w_resp_valid_nxt = onehot2(r_grant);
          w_state_nxt      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready[r_grant]) begin
          w_last_grant_nxt = r_grant;
          w_resp_valid_nxt = 2'b00;
          w_busy_nxt       = 1'b0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: begin
        w_resp_valid_nxt = 2'b00;
        w_busy_nxt       = 1'b0;
        w_state_nxt      = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_fxn    <= '0;
      r_resp_data  <= '0;
      r_resp_valid <= 2'b00;
      r_busy       <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_fxn    <= w_alu_fxn_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_fxn    = r_alu_fxn;
  assign resp_data  = r_resp_data;
  assign resp_valid = r_resp_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: three instances (ALU_LAT 1/3/4) each driving a behavioural ALU,
// with per-instance expected-response queues checked by independent monitors.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int unsigned W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int client;
    int data;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t q4[$];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] f);
    case (f)
      3'b000:  return a;
      3'b001:  return b;
      3'b010:  return -a;
      3'b011:  return -b;
      3'b100:  return {5'b0, (a < b)};
      3'b101:  return ~(a ^ b);
      3'b110:  return a + b;
      default: return a - b;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Instance signals: suffix 1/3/4 = ALU_LAT of that instance.
  logic [1:0] v1 = '0, v3 = '0, v4 = '0;
  logic [1:0] rr1 = '0, rr3 = '0, rr4 = '0;
  logic [2*W-1:0] a1 = '0, b1 = '0, a3 = '0, b3 = '0, a4 = '0, b4 = '0;
  logic [5:0] f1 = '0, f3 = '0, f4 = '0;
  logic [1:0] rdy1, rdy3, rdy4, rv1, rv3, rv4;
  logic [W-1:0] rd1, rd3, rd4, aa1, aa3, aa4, ab1, ab3, ab4, ax1, ax3, ax4;
  logic [2:0] af1, af3, af4;
  logic busy1, busy3, busy4;

  assign ax1 = alu_f(aa1, ab1, af1);
  assign ax3 = alu_f(aa3, ab3, af3);
  assign ax4 = alu_f(aa4, ab4, af4);

  alu_share_ctrl #(.W(W), .ALU_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_a(a1), .req_b(b1),
    .req_fxn(f1), .resp_valid(rv1), .resp_ready(rr1), .resp_data(rd1), .alu_a(aa1),
    .alu_b(ab1), .alu_fxn(af1), .alu_x(ax1), .busy(busy1)
  );
  alu_share_ctrl #(.W(W), .ALU_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_b(b3),
    .req_fxn(f3), .resp_valid(rv3), .resp_ready(rr3), .resp_data(rd3), .alu_a(aa3),
    .alu_b(ab3), .alu_fxn(af3), .alu_x(ax3), .busy(busy3)
  );
  alu_share_ctrl #(.W(W), .ALU_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4), .req_a(a4), .req_b(b4),
    .req_fxn(f4), .resp_valid(rv4), .resp_ready(rr4), .resp_data(rd4), .alu_a(aa4),
    .alu_b(ab4), .alu_fxn(af4), .alu_x(ax4), .busy(busy4)
  );

  // Monitors: pop one expectation per consumed response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((rv1 & rr1) != 2'b00)) begin
      if (q1.size() == 0) chk("u1_unexpected_resp", int'(rv1), 0);
      else begin
        e = q1.pop_front();
        chk("u1_resp_client", int'(rv1), (e.client == 1) ? 2 : 1);
        chk("u1_resp_data", int'(rd1), e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((rv3 & rr3) != 2'b00)) begin
      if (q3.size() == 0) chk("u3_unexpected_resp", int'(rv3), 0);
      else begin
        e = q3.pop_front();
        chk("u3_resp_client", int'(rv3), (e.client == 1) ? 2 : 1);
        chk("u3_resp_data", int'(rd3), e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((rv4 & rr4) != 2'b00)) begin
      if (q4.size() == 0) chk("u4_unexpected_resp", int'(rv4), 0);
      else begin
        e = q4.pop_front();
        chk("u4_resp_client", int'(rv4), (e.client == 1) ? 2 : 1);
        chk("u4_resp_data", int'(rd4), e.data);
      end
    end
  end

  task automatic push1(input int c, input int d);
    exp_t e;
    e.client = c;
    e.data   = d;
    q1.push_back(e);
  endtask

  // Present one request on u1 and hold it until accepted (bounded).
  task automatic op1(input int c, input int a, input int b, input int f);
    @(posedge clk); #1;
    v1[c] = 1'b1;
    a1[c*W +: W] = W'(a);
    b1[c*W +: W] = W'(b);
    f1[c*3 +: 3] = 3'(f);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy1[c]) break;
    end
    chk("u1_req_ready", int'(rdy1[c]), 1);
    @(posedge clk); #1;
    v1[c] = 1'b0;
  endtask

  task automatic drain1();
    for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clk);
    chk("u1_queue_drained", q1.size(), 0);
  endtask

  task automatic wait_rv1();
    for (int i = 0; i < 20 && rv1 == 2'b00; i++) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", int'(rdy1), 0);
    chk("rst_resp_valid", int'(rv1), 0);
    chk("rst_resp_data", int'(rd1), 0);
    chk("rst_alu_a", int'(aa1), 0);
    chk("rst_busy", int'(busy1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_valid_ready", int'(rdy1), 0);
    chk("idle_busy", int'(busy1), 0);

    // Single ops with latency check
    rr1 = 2'b11;
    push1(0, 8);
    op1(0, 5, 3, 6);
    @(negedge clk);
    chk("u1_lat_t1_valid", int'(rv1), 0);
    chk("u1_lat_t1_busy", int'(busy1), 1);
    @(negedge clk);
    chk("u1_lat_t2_valid", int'(rv1), 1);
    push1(0, 'h3D);
    op1(0, 2, 5, 7);
    drain1();

    // Contention from reset, alternating grants
    @(negedge clk);
    rst_n = 1'b0;
    v1 = 2'b11;
    a1 = {6'd4, 6'd1};
    b1 = {6'd1, 6'd1};
    f1 = {3'b111, 3'b110};
    rr1 = 2'b11;
    for (int i = 0; i < 8; i++) push1(i % 2, (i % 2 == 0) ? 2 : 3);
    #1;
    chk("reset_ready_gated", int'(rdy1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("contend_first_grant", int'(rdy1), 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if ((v1 & rdy1) != 2'b00) n++;
      if (n == 8) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    v1 = 2'b00;
    chk("contend_accepts", n, 8);
    drain1();

    // Backpressure; non-granted client's resp_ready must be ignored
    rr1 = 2'b10;
    push1(0, 16);
    op1(0, 7, 9, 6);
    wait_rv1();
    chk("bp_valid", int'(rv1), 1);
    v1[1] = 1'b1;
    a1[2*W-1:W] = 6'h2A;
    b1[2*W-1:W] = 6'h33;
    f1[5:3] = 3'b101;
    push1(1, 'h26);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(rv1), 1);
      chk("bp_hold_data", int'(rd1), 16);
      chk("bp_hold_ready", int'(rdy1), 0);
    end
    @(posedge clk); #1;
    rr1 = 2'b11;
    @(negedge clk);
    chk("bp_release_valid", int'(rv1), 1);
    @(negedge clk);
    chk("bp_idle_busy", int'(busy1), 0);
    chk("bp_idle_ready", int'(rdy1), 2);
    @(posedge clk); #1;
    v1 = 2'b00;
    drain1();

    // Async reset while a response is pending
    rr1 = 2'b00;
    op1(0, 1, 2, 1);
    wait_rv1();
    chk("mid_resp_valid", int'(rv1), 1);
    chk("mid_resp_data", int'(rd1), 2);
    v1 = 2'b01;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(rv1), 0);
    chk("async_rst_data", int'(rd1), 0);
    chk("async_rst_alu_a", int'(aa1), 0);
    chk("async_rst_alu_b", int'(ab1), 0);
    chk("async_rst_alu_fxn", int'(af1), 0);
    chk("async_rst_busy", int'(busy1), 0);
    chk("async_rst_ready", int'(rdy1), 0);
    @(negedge clk);
    v1 = 2'b00;
    rst_n = 1'b1;

    // Reset during EXEC on the ALU_LAT=4 instance
    rr4 = 2'b11;
    @(posedge clk); #1;
    v4 = 2'b01;
    a4[W-1:0] = 6'd3;
    b4[W-1:0] = 6'd4;
    f4[2:0] = 3'b110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy4[0]) break;
    end
    chk("u4_req_ready0", int'(rdy4[0]), 1);
    @(posedge clk); #1;
    v4 = 2'b00;
    repeat (2) @(negedge clk);
    chk("u4_exec_busy", int'(busy4), 1);
    rst_n = 1'b0;
    #1;
    chk("u4_rst_busy", int'(busy4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("u4_dropped_op_valid", int'(rv4), 0);
    end
    e.client = 1;
    e.data   = 7;
    q4.push_back(e);
    @(posedge clk); #1;
    v4 = 2'b10;
    a4[2*W-1:W] = 6'd3;
    b4[2*W-1:W] = 6'd4;
    f4[5:3] = 3'b110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy4[1]) break;
    end
    chk("u4_req_ready1", int'(rdy4[1]), 1);
    @(posedge clk); #1;
    v4 = 2'b00;
    for (int i = 0; i < 20 && q4.size() != 0; i++) @(negedge clk);
    chk("u4_queue_drained", q4.size(), 0);

    // ALU_LAT=3 latency with LT
    rr3 = 2'b01;
    e.client = 0;
    e.data   = 1;
    q3.push_back(e);
    @(posedge clk); #1;
    v3 = 2'b01;
    a3[W-1:0] = 6'd2;
    b3[W-1:0] = 6'd7;
    f3[2:0] = 3'b100;
    @(negedge clk);
    chk("u3_t0_ready", int'(rdy3), 1);
    @(posedge clk); #1;
    v3 = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("u3_early_valid", int'(rv3), 0);
    end
    @(negedge clk);
    chk("u3_t4_valid", int'(rv3), 1);
    chk("u3_t4_data", int'(rd3), 1);
    for (int i = 0; i < 10 && q3.size() != 0; i++) @(negedge clk);
    chk("u3_queue_drained", q3.size(), 0);

    repeat (3) @(negedge clk);
    chk("final_q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
